// File: rtl/line_fill_engine.sv
// -----------------------------------------------------------------------------
// line_fill_engine
//
// Bus-side read engine on the cache miss path. It accepts one line-fill
// request, wins the shared main bus, issues one tagged read and gathers the
// response beats into a full cache line. The line goes back to the cache with
// a one-cycle completion pulse. Only one fill is outstanding at a time.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   req_valid/req_ready fill request handshake from the cache (req_addr is a
//   req_addr            byte address, the low line-offset bits are dropped)
//   fill_valid          one-cycle pulse: fill_data/fill_addr hold the line
//   fill_data           assembled line, beat i at [i*BUS_DATA_WIDTH +: W]
//   fill_addr           line-aligned address of the fill
//   busy                high in every state except IDLE
//   abtr_reqcyc/grant   bus arbiter request / grant
//   bus_reqcyc/req/     read request (valid / address / tag) and its
//   bus_reqtag/reqack   acceptance
//   bus_respcyc/resp/   response beat (valid / data / tag) and the
//   bus_resptag/respack beat acknowledge
//
// Bus-facing outputs are forced to zero outside the states that drive them so
// the parent can OR them with the store-side engine.
// -----------------------------------------------------------------------------
module line_fill_engine #(
    parameter int                     BUS_DATA_WIDTH = 64,
    parameter int                     BUS_TAG_WIDTH  = 13,
    parameter int                     LINE_BYTES     = 64,
    parameter logic [BUS_TAG_WIDTH-1:0] READ_TAG     = 13'h1100
) (
    input  logic                          clk,
    input  logic                          reset,

    input  logic                          req_valid,
    input  logic [63:0]                   req_addr,
    output logic                          req_ready,

    output logic                          fill_valid,
    output logic [LINE_BYTES*8-1:0]       fill_data,
    output logic [63:0]                   fill_addr,
    output logic                          busy,

    output logic                          abtr_reqcyc,
    input  logic                          abtr_grant,

    output logic                          bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0]     bus_req,
    output logic [BUS_TAG_WIDTH-1:0]      bus_reqtag,
    input  logic                          bus_reqack,

    input  logic                          bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0]     bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]      bus_resptag,
    output logic                          bus_respack
);

    localparam int LINE_W = LINE_BYTES * 8;
    localparam int BEATS  = LINE_W / BUS_DATA_WIDTH;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [63:0]      LINE_MASK = ~(64'(LINE_BYTES) - 64'd1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARB  = 3'd1,
        REQ  = 3'd2,
        RESP = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [63:0]      line_addr;
    logic [LINE_W-1:0] line_data;
    logic [CNT_W-1:0] beat_cnt;

    logic             accept;
    logic             beat_take;

    // A request is taken only in IDLE; a beat only in RESP with the read tag.
    assign accept    = (state == IDLE) && req_valid;
    assign beat_take = (state == RESP) && bus_respcyc && (bus_resptag == READ_TAG);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (req_valid)  state_next = ARB;
            ARB:  if (abtr_grant) state_next = REQ;
            REQ:  if (bus_reqack) state_next = RESP;
            // Grant is not re-checked here: ownership is held until DONE.
            RESP: if (beat_take && (beat_cnt == LAST_BEAT)) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic
    // -------------------------------------------------------------------------
    always_comb begin
        req_ready   = 1'b0;
        busy        = 1'b1;
        fill_valid  = 1'b0;
        abtr_reqcyc = 1'b0;
        bus_reqcyc  = 1'b0;
        bus_req     = '0;
        bus_reqtag  = '0;
        bus_respack = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
            end
            ARB: begin
                abtr_reqcyc = 1'b1;
            end
            REQ: begin
                abtr_reqcyc = 1'b1;
                bus_reqcyc  = 1'b1;
                bus_req     = BUS_DATA_WIDTH'(line_addr);
                bus_reqtag  = READ_TAG;
            end
            RESP: begin
                abtr_reqcyc = 1'b1;
                bus_respack = beat_take;
            end
            DONE: begin
                fill_valid = 1'b1;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Line address, beat counter and line assembly
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            line_addr <= '0;
            line_data <= '0;
            beat_cnt  <= '0;
        end else if (accept) begin
            // Previous line stays visible until this point; a new request
            // starts from a clean line and slot 0.
            line_addr <= req_addr & LINE_MASK;
            line_data <= '0;
            beat_cnt  <= '0;
        end else if (beat_take) begin
            for (int i = 0; i < BEATS; i++) begin
                if (beat_cnt == CNT_W'(i)) begin
                    line_data[i*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] <= bus_resp;
                end
            end
            beat_cnt <= beat_cnt + CNT_W'(1);
        end
    end

    assign fill_data = line_data;
    assign fill_addr = line_addr;

endmodule

// File: tb/tb_line_fill_engine.sv
// -----------------------------------------------------------------------------
// tb_line_fill_engine
//
// Directed bench for line_fill_engine. A small reactive bus/arbiter driver
// (do_fill) services one fill with programmable grant / reqack wait states and
// an optional foreign-tag beat, and reports what it observed. Each test task
// compares those observations against hand-computed values.
//
// Cycle numbering used throughout: the cycle in which the request is accepted
// (IDLE with req_valid high) is cycle 1, so a zero-wait fill shows fill_valid
// in cycle 12 (1 IDLE + 1 ARB + 1 REQ + 8 RESP + DONE).
// -----------------------------------------------------------------------------
module tb_line_fill_engine;

    localparam logic [12:0] READ_TAG = 13'h1100;

    logic         clk;
    logic         reset;
    logic         req_valid;
    logic [63:0]  req_addr;
    logic         req_ready;
    logic         fill_valid;
    logic [511:0] fill_data;
    logic [63:0]  fill_addr;
    logic         busy;
    logic         abtr_reqcyc;
    logic         abtr_grant;
    logic         bus_reqcyc;
    logic [63:0]  bus_req;
    logic [12:0]  bus_reqtag;
    logic         bus_reqack;
    logic         bus_respcyc;
    logic [63:0]  bus_resp;
    logic [12:0]  bus_resptag;
    logic         bus_respack;

    int n_cmp;
    int n_bad;

    line_fill_engine dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_ready   (req_ready),
        .fill_valid  (fill_valid),
        .fill_data   (fill_data),
        .fill_addr   (fill_addr),
        .busy        (busy),
        .abtr_reqcyc (abtr_reqcyc),
        .abtr_grant  (abtr_grant),
        .bus_reqcyc  (bus_reqcyc),
        .bus_req     (bus_req),
        .bus_reqtag  (bus_reqtag),
        .bus_reqack  (bus_reqack),
        .bus_respcyc (bus_respcyc),
        .bus_resp    (bus_resp),
        .bus_resptag (bus_resptag),
        .bus_respack (bus_respack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_bus();
        abtr_grant  = 1'b0;
        bus_reqack  = 1'b0;
        bus_respcyc = 1'b0;
        bus_resp    = '0;
        bus_resptag = '0;
    endtask

    // Drives one fill from the current cycle (called at posedge+1 with the
    // engine in IDLE). Returns at posedge+1 of the cycle after fill_valid.
    // errs counts protocol violations: request fields not equal to the
    // expected address/tag, wrong beat acks, req_ready high while busy,
    // fill_valid wider than one cycle.
    task automatic do_fill(input  logic [63:0]  addr,
                           input  int           gwait,
                           input  int           await_n,
                           input  int           bad_after,
                           input  logic         hold,
                           input  logic [63:0]  next_addr,
                           input  logic [63:0]  pat,
                           output int           fv_cycle,
                           output logic [511:0] data,
                           output logic [63:0]  faddr,
                           output int           txn,
                           output int           errs,
                           output logic         ready0);
        logic       granted;
        logic       acked;
        logic       bad_done;
        logic       prev_reqcyc;
        logic       drive_beat;
        logic       expect_ack;
        int         gcnt;
        int         acnt;
        int         beat;
        logic [63:0] line;
        line        = {addr[63:6], 6'b0};
        granted     = 1'b0;
        acked       = 1'b0;
        bad_done    = 1'b0;
        prev_reqcyc = 1'b0;
        gcnt        = 0;
        acnt        = 0;
        beat        = 0;
        fv_cycle    = -1;
        data        = '0;
        faddr       = '0;
        txn         = 0;
        errs        = 0;

        // cycle 1: present the request
        clear_bus();
        req_valid = 1'b1;
        req_addr  = addr;
        #1;
        ready0 = req_ready;
        @(posedge clk); #1;
        if (hold) begin
            req_addr = next_addr;
        end else begin
            req_valid = 1'b0;
            req_addr  = 64'hFFFF_0000_FFFF_0000;
        end

        for (int cyc = 2; cyc < 200; cyc++) begin
            clear_bus();
            drive_beat = 1'b0;
            expect_ack = 1'b0;
            if (busy && req_ready) errs++;
            if (bus_reqcyc && !prev_reqcyc) txn++;
            prev_reqcyc = bus_reqcyc;
            if (fill_valid) begin
                fv_cycle = cyc;
                data     = fill_data;
                faddr    = fill_addr;
            end else if (!granted) begin
                if (abtr_reqcyc) begin
                    if (gcnt == gwait) begin
                        abtr_grant = 1'b1;
                        granted    = 1'b1;
                    end else begin
                        // stray beat while arbitrating: must not be taken
                        bus_respcyc = 1'b1;
                        bus_resptag = READ_TAG;
                        bus_resp    = 64'hDEAD_BEEF_DEAD_BEEF;
                        drive_beat  = 1'b1;
                    end
                    gcnt++;
                end
            end else if (!acked) begin
                if (bus_reqcyc) begin
                    if (bus_req !== line || bus_reqtag !== READ_TAG) errs++;
                    if (acnt == await_n) begin
                        bus_reqack = 1'b1;
                        acked      = 1'b1;
                    end
                    acnt++;
                end
            end else if (beat < 8) begin
                drive_beat  = 1'b1;
                bus_respcyc = 1'b1;
                if (bad_after >= 0 && beat == bad_after + 1 && !bad_done) begin
                    bus_resptag = 13'h0001;
                    bus_resp    = 64'hFFFF_FFFF_FFFF_FFFF;
                    bad_done    = 1'b1;
                end else begin
                    bus_resptag = READ_TAG;
                    bus_resp    = pat | 64'(beat);
                    expect_ack  = 1'b1;
                    beat++;
                end
            end
            #1;
            if (drive_beat && (bus_respack !== expect_ack)) errs++;
            @(posedge clk); #1;
            if (fv_cycle >= 0) begin
                if (fill_valid !== 1'b0) errs++;
                break;
            end
        end
        clear_bus();
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        clear_bus();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (fill_valid !== 1'b0) begin n_bad++; $display("FAIL reset_fill_valid got %b want 0", fill_valid); end
        n_cmp++; if ({abtr_reqcyc, bus_reqcyc, bus_respack} !== 3'b000) begin n_bad++; $display("FAIL reset_bus_ctl got %b want 000", {abtr_reqcyc, bus_reqcyc, bus_respack}); end
        n_cmp++; if (bus_req !== 64'h0 || bus_reqtag !== 13'h0) begin n_bad++; $display("FAIL reset_bus_req got %h/%h want 0/0", bus_req, bus_reqtag); end
        n_cmp++; if (fill_data !== 512'h0) begin n_bad++; $display("FAIL reset_fill_data got %h want 0", fill_data); end
        n_cmp++; if (fill_addr !== 64'h0) begin n_bad++; $display("FAIL reset_fill_addr got %h want 0", fill_addr); end
    endtask

    task automatic test_single_fill();
        int fv, txn, errs;
        logic rdy;
        logic [511:0] d, exp;
        logic [63:0] fa;
        for (int k = 0; k < 8; k++) exp[64*k +: 64] = 64'hA5A5_0000_0000_0000 | 64'(k);
        do_fill(64'h0000_1234_5678_9A7F, 0, 0, -1, 1'b0, 64'h0, 64'hA5A5_0000_0000_0000,
                fv, d, fa, txn, errs, rdy);
        n_cmp++; if (rdy !== 1'b1) begin n_bad++; $display("FAIL single_req_ready got %b want 1", rdy); end
        n_cmp++; if (fv !== 12) begin n_bad++; $display("FAIL single_latency got %0d want 12", fv); end
        n_cmp++; if (fa !== 64'h0000_1234_5678_9A40) begin n_bad++; $display("FAIL single_fill_addr got %h want %h", fa, 64'h0000_1234_5678_9A40); end
        n_cmp++; if (d !== exp) begin n_bad++; $display("FAIL single_fill_data got %h want %h", d, exp); end
        n_cmp++; if (txn !== 1) begin n_bad++; $display("FAIL single_reqcyc_txn got %0d want 1", txn); end
        n_cmp++; if (errs !== 0) begin n_bad++; $display("FAIL single_protocol got %0d want 0", errs); end
        // Completed line stays on the outputs while idle.
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (fill_data !== exp || fill_addr !== 64'h0000_1234_5678_9A40) begin n_bad++; $display("FAIL single_hold got %h want %h", fill_data, exp); end
    endtask

    task automatic test_wait_states();
        int fv, txn, errs;
        logic rdy;
        logic [511:0] d, exp;
        logic [63:0] fa;
        for (int k = 0; k < 8; k++) exp[64*k +: 64] = 64'h3C3C_1111_0000_0000 | 64'(k);
        do_fill(64'h0000_0000_0000_1000, 5, 3, -1, 1'b0, 64'h0, 64'h3C3C_1111_0000_0000,
                fv, d, fa, txn, errs, rdy);
        n_cmp++; if (fv !== 20) begin n_bad++; $display("FAIL wait_latency got %0d want 20", fv); end
        n_cmp++; if (d !== exp) begin n_bad++; $display("FAIL wait_fill_data got %h want %h", d, exp); end
        n_cmp++; if (fa !== 64'h0000_0000_0000_1000) begin n_bad++; $display("FAIL wait_fill_addr got %h want 1000", fa); end
        n_cmp++; if (txn !== 1) begin n_bad++; $display("FAIL wait_reqcyc_txn got %0d want 1", txn); end
        n_cmp++; if (errs !== 0) begin n_bad++; $display("FAIL wait_protocol got %0d want 0", errs); end
    endtask

    task automatic test_foreign_tag();
        int fv, txn, errs;
        logic rdy;
        logic [511:0] d, exp;
        logic [63:0] fa;
        for (int k = 0; k < 8; k++) exp[64*k +: 64] = 64'h0123_4567_0000_0000 | 64'(k);
        do_fill(64'hFFFF_FFFF_FFFF_FFC1, 0, 0, 3, 1'b0, 64'h0, 64'h0123_4567_0000_0000,
                fv, d, fa, txn, errs, rdy);
        n_cmp++; if (fv !== 13) begin n_bad++; $display("FAIL tag_latency got %0d want 13", fv); end
        n_cmp++; if (d !== exp) begin n_bad++; $display("FAIL tag_fill_data got %h want %h", d, exp); end
        n_cmp++; if (fa !== 64'hFFFF_FFFF_FFFF_FFC0) begin n_bad++; $display("FAIL tag_fill_addr got %h want FFFFFFFFFFFFFFC0", fa); end
        n_cmp++; if (errs !== 0) begin n_bad++; $display("FAIL tag_protocol got %0d want 0", errs); end
    endtask

    task automatic test_back_to_back();
        int fv1, txn1, errs1, fv2, txn2, errs2;
        logic rdy1, rdy2;
        logic [511:0] d1, d2, exp1, exp2;
        logic [63:0] fa1, fa2;
        for (int k = 0; k < 8; k++) begin
            exp1[64*k +: 64] = 64'h1111_0000_0000_0000 | 64'(k);
            exp2[64*k +: 64] = 64'h2222_0000_0000_0000 | 64'(k);
        end
        do_fill(64'h0000_0000_ABCD_0008, 0, 0, -1, 1'b1, 64'h0000_0000_5555_0030,
                64'h1111_0000_0000_0000, fv1, d1, fa1, txn1, errs1, rdy1);
        do_fill(64'h0000_0000_5555_0030, 0, 0, -1, 1'b0, 64'h0,
                64'h2222_0000_0000_0000, fv2, d2, fa2, txn2, errs2, rdy2);
        n_cmp++; if (fv1 !== 12) begin n_bad++; $display("FAIL b2b_first_latency got %0d want 12", fv1); end
        n_cmp++; if (fa1 !== 64'h0000_0000_ABCD_0000) begin n_bad++; $display("FAIL b2b_first_addr got %h want ABCD0000", fa1); end
        n_cmp++; if (errs1 !== 0) begin n_bad++; $display("FAIL b2b_first_protocol got %0d want 0", errs1); end
        n_cmp++; if (rdy2 !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_after_fill got %b want 1", rdy2); end
        n_cmp++; if (fv2 !== 12) begin n_bad++; $display("FAIL b2b_second_latency got %0d want 12", fv2); end
        n_cmp++; if (fa2 !== 64'h0000_0000_5555_0000) begin n_bad++; $display("FAIL b2b_second_addr got %h want 55550000", fa2); end
        n_cmp++; if (d1 !== exp1 || d2 !== exp2) begin n_bad++; $display("FAIL b2b_data got %h want %h", d2, exp2); end
    endtask

    task automatic test_reset_mid_fill();
        int acks, fv_seen, fv, txn, errs;
        logic rdy;
        logic [511:0] d, exp;
        logic [63:0] fa;
        acks    = 0;
        fv_seen = 0;
        clear_bus();
        req_valid = 1'b1;
        req_addr  = 64'h0000_0000_0BAD_0100;
        @(posedge clk); #1;
        req_valid  = 1'b0;
        abtr_grant = 1'b1;
        @(posedge clk); #1;
        abtr_grant = 1'b0;
        bus_reqack = 1'b1;
        @(posedge clk); #1;
        bus_reqack = 1'b0;
        for (int k = 0; k < 6; k++) begin
            bus_respcyc = 1'b1;
            bus_resptag = READ_TAG;
            bus_resp    = 64'h7777_0000_0000_0000 | 64'(k);
            #1;
            if (bus_respack === 1'b1) acks++;
            @(posedge clk); #1;
        end
        bus_respcyc = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        // Good-tag beat presented in IDLE must not be acked.
        bus_respcyc = 1'b1;
        bus_resptag = READ_TAG;
        bus_resp    = 64'h7777_0000_0000_0006;
        #1;
        n_cmp++; if (acks !== 6) begin n_bad++; $display("FAIL rst_pre_acks got %0d want 6", acks); end
        n_cmp++; if (req_ready !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL rst_idle got ready=%b busy=%b want 1/0", req_ready, busy); end
        n_cmp++; if ({abtr_reqcyc, bus_reqcyc, bus_respack} !== 3'b000) begin n_bad++; $display("FAIL rst_bus_ctl got %b want 000", {abtr_reqcyc, bus_reqcyc, bus_respack}); end
        n_cmp++; if (bus_req !== 64'h0 || bus_reqtag !== 13'h0) begin n_bad++; $display("FAIL rst_bus_req got %h/%h want 0/0", bus_req, bus_reqtag); end
        n_cmp++; if (fill_data !== 512'h0 || fill_addr !== 64'h0) begin n_bad++; $display("FAIL rst_cleared got %h / %h want 0", fill_data, fill_addr); end
        clear_bus();
        for (int c = 0; c < 4; c++) begin
            if (fill_valid === 1'b1) fv_seen++;
            @(posedge clk); #1;
        end
        n_cmp++; if (fv_seen !== 0) begin n_bad++; $display("FAIL rst_no_fill_valid got %0d want 0", fv_seen); end

        for (int k = 0; k < 8; k++) exp[64*k +: 64] = 64'h9999_0000_0000_0000 | 64'(k);
        do_fill(64'h0000_0000_0BAD_0100, 0, 0, -1, 1'b0, 64'h0, 64'h9999_0000_0000_0000,
                fv, d, fa, txn, errs, rdy);
        n_cmp++; if (fv !== 12) begin n_bad++; $display("FAIL rst_refill_latency got %0d want 12", fv); end
        n_cmp++; if (d !== exp) begin n_bad++; $display("FAIL rst_refill_data got %h want %h", d, exp); end
        n_cmp++; if (fa !== 64'h0000_0000_0BAD_0100) begin n_bad++; $display("FAIL rst_refill_addr got %h want 0BAD0100", fa); end
        n_cmp++; if (errs !== 0) begin n_bad++; $display("FAIL rst_refill_protocol got %0d want 0", errs); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_single_fill();
        test_wait_states();
        test_foreign_tag();
        test_back_to_back();
        test_reset_mid_fill();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard stop in case the run never reaches the summary.
    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
